// File: rtl/core_pkg.sv
// Shared state encodings, opcode constants and decode helpers for the core sequencer.
// The TRAP state exists only when ILLEGAL_TRAP_EN is defined.
package core_pkg;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4
    } state_t;
`endif

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    function automatic logic is_wb_op(input logic [6:0] op);
        return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JALR);
    endfunction

    // Only recognised opcodes that produce a result may write the register file.
    function automatic logic writes_rd(input logic [6:0] op);
        return is_wb_op(op) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: synchronous clear, increment enable, silent wrap.
module retire_counter #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 inc_en,
    output logic [INSTRET_W-1:0] count
);
    logic [INSTRET_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc_en) begin
            count_reg <= count_reg + INSTRET_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK control strobes.
// Define ILLEGAL_TRAP_EN to send illegal opcodes to a sticky TRAP state (adds trap_o).
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter int         INSTRET_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [6:0]           opcode_i,
    output logic                 imem_req_o,
    input  logic                 imem_ack_i,
    output logic                 ir_load_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    input  logic                 dmem_ack_i,
    output logic                 reg_write_o,
    output logic                 pc_write_o,
`ifdef ILLEGAL_TRAP_EN
    output logic                 trap_o,
`endif
    output logic [2:0]           state_o,
    output logic [INSTRET_W-1:0] instret_o
);
    state_t state_reg;
    state_t state_next;
    logic   retire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= state_t'(RESET_STATE);
        end else begin
            state_reg <= state_next;
        end
    end

    // Strobes are suppressed while reset is asserted so an abandoned access never retires.
    always_comb begin
        state_next  = state_reg;
        imem_req_o  = 1'b0;
        ir_load_o   = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        reg_write_o = 1'b0;
        pc_write_o  = 1'b0;
        retire      = 1'b0;
        if (!rst_i) begin
            case (state_reg)
                FETCH: begin
                    imem_req_o = 1'b1;
                    if (imem_ack_i) begin
                        ir_load_o  = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    state_next = EXECUTE;
                end
                EXECUTE: begin
                    if ((opcode_i == OP_LOAD) || (opcode_i == OP_STORE)) begin
                        state_next = MEM;
                    end else if (is_wb_op(opcode_i)) begin
                        state_next = WRITEBACK;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_next = TRAP;
`else
                        state_next = WRITEBACK;
`endif
                    end
                end
                MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = (opcode_i == OP_STORE);
                    if (dmem_ack_i) begin
                        if (opcode_i == OP_STORE) begin
                            pc_write_o = 1'b1;
                            retire     = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WRITEBACK;
                        end
                    end
                end
                WRITEBACK: begin
                    reg_write_o = writes_rd(opcode_i);
                    pc_write_o  = 1'b1;
                    retire      = 1'b1;
                    state_next  = FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                TRAP: begin
                    state_next = TRAP;
                end
`endif
                default: begin
                    state_next = state_t'(RESET_STATE);
                end
            endcase
        end
    end

    retire_counter #(
        .INSTRET_W(INSTRET_W)
    ) u_retire_counter (
        .clk    (clk_i),
        .clr    (rst_i),
        .inc_en (retire),
        .count  (instret_o)
    );

    assign state_o = state_reg;
`ifdef ILLEGAL_TRAP_EN
    assign trap_o  = (state_reg == TRAP);
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer; a narrow counter width keeps the wrap check short.
module tb_core_sequencer;
    import core_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [6:0]    opcode_i = 7'd0;
    logic          imem_ack_i = 1'b0;
    logic          dmem_ack_i = 1'b0;
    logic          imem_req_o, ir_load_o, dmem_req_o, dmem_we_o, reg_write_o, pc_write_o;
    logic [2:0]    state_o;
    logic [CW-1:0] instret_o;
`ifdef ILLEGAL_TRAP_EN
    logic          trap_o;
`endif

    core_sequencer #(
        .RESET_STATE (3'd0),
        .INSTRET_W   (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .opcode_i    (opcode_i),
        .imem_req_o  (imem_req_o),
        .imem_ack_i  (imem_ack_i),
        .ir_load_o   (ir_load_o),
        .dmem_req_o  (dmem_req_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_ack_i  (dmem_ack_i),
        .reg_write_o (reg_write_o),
        .pc_write_o  (pc_write_o),
`ifdef ILLEGAL_TRAP_EN
        .trap_o      (trap_o),
`endif
        .state_o     (state_o),
        .instret_o   (instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]    op;
        int            lat;
        logic [31:0]   trace;
        int            rw;
        int            req;
        int            we;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] model_cnt = '0;
    logic [5:0]    strobes;

    assign strobes = {imem_req_o, ir_load_o, dmem_req_o, dmem_we_o, reg_write_o, pc_write_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Ends on a negedge with reset released and the model counter cleared.
    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_i = 1'b1;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_instret", 32'(instret_o), 32'd0);
        check("rst_strobes", 32'(strobes), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        check("rst_trap", 32'(trap_o), 32'd0);
`endif
        @(negedge clk);
        rst_i = 1'b0;
        model_cnt = '0;
        #1;
        check("post_rst_imem_req", 32'(imem_req_o), 32'd1);
    endtask

    // Drives one instruction from FETCH entry; pushes expectation, pops it on pc_write_o.
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input logic noise,
                             input int lat, input logic [31:0] trace, input int rw,
                             input int req, input int we);
        exp_t        e;
        int          cyc = 0, fw = 0, dwc = 0, irl = 0, rwc = 0, reqc = 0, wec = 0;
        logic [31:0] tr = '0;
        logic        done = 1'b0;
        e.op = op; e.lat = lat; e.trace = trace; e.rw = rw; e.req = req; e.we = we;
        e.cnt = model_cnt;
        sb.push_back(e);
        model_cnt = model_cnt + 1'b1;
        opcode_i = op;
        while (!done && cyc < 60) begin
            imem_ack_i = (state_o == FETCH) ? (fw == iw) : noise;
            dmem_ack_i = (state_o == MEM) ? (dwc == dw) : noise;
            #1;
            tr = {tr[27:0], 1'b0, state_o + 3'd1};
            if (state_o == FETCH) fw++;
            if (state_o == MEM) dwc++;
            irl += int'(ir_load_o);
            rwc += int'(reg_write_o);
            reqc += int'(dmem_req_o);
            wec += int'(dmem_we_o);
            cyc++;
            if (pc_write_o) begin
                e = sb.pop_front();
                check("latency", 32'(cyc), 32'(e.lat));
                check("state_trace", tr, e.trace);
                check("reg_write_cycles", 32'(rwc), 32'(e.rw));
                check("dmem_req_cycles", 32'(reqc), 32'(e.req));
                check("dmem_we_cycles", 32'(wec), 32'(e.we));
                check("ir_load_cycles", 32'(irl), 32'd1);
                check("instret_pre", 32'(instret_o), 32'(e.cnt));
                $display("txn op=%b lat=%0d trace=%0h instret=%0d", op, cyc, tr, instret_o);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check("retire_timeout", 32'd0, 32'd1);
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        #1;
        check("instret_post", 32'(instret_o), 32'(model_cnt));
        check("back_to_fetch", 32'(state_o), 32'(FETCH));
        @(negedge clk);
    endtask

    initial begin
        int guard;
        apply_reset(2);

        run_instr(OP_LUI,   0, 0, 1'b0, 4, 32'h1235,     1, 0, 0);
        run_instr(OP_LOAD,  0, 3, 1'b0, 8, 32'h12344445, 1, 4, 0);
        run_instr(OP_STORE, 0, 0, 1'b0, 4, 32'h1234,     0, 1, 1);
        run_instr(OP_STORE, 0, 2, 1'b0, 6, 32'h123444,   0, 3, 3);
        run_instr(OP_AUIPC, 2, 0, 1'b0, 6, 32'h111235,   1, 0, 0);
        run_instr(OP_JALR,  1, 0, 1'b1, 5, 32'h11235,    1, 0, 0);
        run_instr(OP_LOAD,  0, 0, 1'b1, 5, 32'h12345,    1, 1, 0);

`ifdef ILLEGAL_TRAP_EN
        opcode_i = 7'b1110011;
        guard = 0;
        while (state_o != EXECUTE && guard < 20) begin
            imem_ack_i = (state_o == FETCH);
            @(negedge clk);
            guard++;
        end
        check("reach_execute", 32'(state_o), 32'(EXECUTE));
        imem_ack_i = 1'b1;
        dmem_ack_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            #1;
            check("trap_state", 32'(state_o), 32'd5);
            check("trap_flag", 32'(trap_o), 32'd1);
            check("trap_strobes", 32'(strobes), 32'd0);
            @(negedge clk);
        end
        check("trap_instret", 32'(instret_o), 32'(model_cnt));
        $display("txn op=1110011 trapped for 20 cycles");
        apply_reset(1);
`else
        guard = 0;
        run_instr(7'b1110011, 0, 0, 1'b0, 4, 32'h1235, 0, 0, 0);
`endif

        // Reset while a load waits for its data ack, then deliver the ack late.
        opcode_i = OP_LOAD;
        guard = 0;
        while (state_o != MEM && guard < 20) begin
            imem_ack_i = (state_o == FETCH);
            dmem_ack_i = 1'b0;
            @(negedge clk);
            guard++;
        end
        imem_ack_i = 1'b0;
        #1;
        check("mem_req_before_rst", 32'(dmem_req_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        model_cnt = '0;
        dmem_ack_i = 1'b1;
        #1;
        check("abort_state", 32'(state_o), 32'd0);
        check("abort_instret", 32'(instret_o), 32'd0);
        check("abort_dmem_req", 32'(dmem_req_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("late_ack_state", 32'(state_o), 32'd0);
            check("late_ack_instret", 32'(instret_o), 32'd0);
        end
        $display("txn reset mid-MEM, late ack ignored");
        dmem_ack_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < (1 << CW) - 1; i++) begin
            run_instr(OP_LUI, 0, 0, 1'b0, 4, 32'h1235, 1, 0, 0);
        end
        check("instret_all_ones", 32'(instret_o), 32'(2 ** CW - 1));
        run_instr(OP_LUI, 0, 0, 1'b0, 4, 32'h1235, 1, 0, 0);
        check("instret_wrap", 32'(instret_o), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
